// File: rtl/count_sequencer_pkg.sv
// count_sequencer_pkg: shared constants and state encoding for the counter
// sequencer and the 4-bit loadable counter it drives.
//   COUNT_WIDTH  - counter data path width (also used by the counter)
//   REP_WIDTH    - width of the repeat-count field
//   seq_state_t  - sequencer FSM states
package count_sequencer_pkg;

    localparam int unsigned COUNT_WIDTH = 4;
    localparam int unsigned REP_WIDTH   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/count_sequencer_if.sv
// count_sequencer_if: command and counter-control signals of the sequencer.
//   Command side : Start, Abort, Hold, Preset, Reps  (into sequencer)
//   Status side  : Busy, Done, Pass_idx              (out of sequencer)
//   Counter side : Load, Count, Data_out (out), C_out (in)
// modport slave is the sequencer; modport master is whoever drives it.
interface count_sequencer_if
    import count_sequencer_pkg::*;
    #(
        parameter int unsigned WIDTH = COUNT_WIDTH,
        parameter int unsigned REP_W = REP_WIDTH
    ) ();

    logic             Start;
    logic             Abort;
    logic             Hold;
    logic [WIDTH-1:0] Preset;
    logic [REP_W-1:0] Reps;
    logic             C_out;
    logic             Load;
    logic             Count;
    logic [WIDTH-1:0] Data_out;
    logic             Busy;
    logic             Done;
    logic [REP_W-1:0] Pass_idx;

    modport master (
        output Start, Abort, Hold, Preset, Reps, C_out,
        input  Load, Count, Data_out, Busy, Done, Pass_idx
    );

    modport slave (
        input  Start, Abort, Hold, Preset, Reps, C_out,
        output Load, Count, Data_out, Busy, Done, Pass_idx
    );

endinterface

// File: rtl/count_sequencer.sv
// count_sequencer: runs the loadable counter from a latched preset up to
// terminal count, Reps+1 times, then pulses Done.
//   CLK   - rising-edge clock shared with the counter
//   Reset - asynchronous active-high reset
//   bus   - count_sequencer_if.slave: command inputs, counter Load/Count/
//           Data_out outputs, counter C_out input, Busy/Done/Pass_idx status
module count_sequencer
    import count_sequencer_pkg::*;
    #(
        parameter int unsigned WIDTH = COUNT_WIDTH,
        parameter int unsigned REP_W = REP_WIDTH
    ) (
        input logic              CLK,
        input logic              Reset,
        count_sequencer_if.slave bus
    );

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [WIDTH-1:0] data_q;
    logic [REP_W-1:0] rep_left;
    logic [REP_W-1:0] pass_q;
    logic             accept;
    logic             pass_end;

    assign accept   = (state == IDLE) && bus.Start && !bus.Abort;
    // Terminal count is ignored while holding so a pass can never end then.
    assign pass_end = (state == RUN) && bus.C_out && !bus.Hold && !bus.Abort;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.Abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (bus.Start) state_nxt = LOAD;
                LOAD: state_nxt = RUN;
                RUN: begin
                    if (pass_end) begin
                        state_nxt = (rep_left == '0) ? DONE : LOAD;
                    end
                end
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Preset/Reps are only captured on an accepted Start; Abort leaves them.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            data_q   <= '0;
            rep_left <= '0;
            pass_q   <= '0;
        end else if (accept) begin
            data_q   <= bus.Preset;
            rep_left <= bus.Reps;
            pass_q   <= '0;
        end else if (pass_end && (rep_left != '0)) begin
            rep_left <= rep_left - REP_W'(1);
            pass_q   <= pass_q + REP_W'(1);
        end
    end

    // Count follows Hold in the same cycle so the counter freezes immediately.
    always_comb begin
        bus.Load  = 1'b0;
        bus.Count = 1'b0;
        bus.Busy  = 1'b0;
        bus.Done  = 1'b0;
        case (state)
            IDLE: ;
            LOAD: begin
                bus.Load = 1'b1;
                bus.Busy = 1'b1;
            end
            RUN: begin
                bus.Count = !bus.Hold;
                bus.Busy  = 1'b1;
            end
            DONE: begin
                bus.Done = 1'b1;
                bus.Busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.Data_out = data_q;
    assign bus.Pass_idx = pass_q;

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed bench for count_sequencer with a behavioural
// 4-bit loadable counter in the loop. Expected completions (busy length,
// latched preset, final pass index) are queued when a run is started and
// checked when Done pulses; cycle-level checks are made inline.
module tb_count_sequencer;
    import count_sequencer_pkg::*;

    typedef struct {
        int unsigned busy;
        logic [3:0]  data;
        logic [3:0]  pass;
    } exp_t;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] cnt_q;
    int         checks = 0;
    int         failures = 0;
    int         done_cnt = 0;
    int         busy_cnt = 0;
    exp_t       sb[$];

    count_sequencer_if #(.WIDTH(4), .REP_W(4)) sif ();

    count_sequencer #(.WIDTH(4), .REP_W(4)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (sif)
    );

    always #5 CLK = ~CLK;

    // Stand-in for the 4-bit loadable counter.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)          cnt_q <= '0;
        else if (sif.Load)  cnt_q <= sif.Data_out;
        else if (sif.Count) cnt_q <= cnt_q + 4'd1;
    end
    assign sif.C_out = sif.Count && (cnt_q == 4'hF);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input int unsigned busy, input logic [3:0] data, input logic [3:0] pass);
        exp_t e;
        e.busy = busy;
        e.data = data;
        e.pass = pass;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        int start_cnt;
        start_cnt = done_cnt;
        for (int i = 0; i < budget && done_cnt == start_cnt; i++) @(posedge CLK);
        chk("done_seen", 32'(done_cnt != start_cnt), 32'd1);
        cyc();
        cyc();
    endtask

    // Completion monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        exp_t e;
        if (Reset) begin
            busy_cnt = 0;
        end else begin
            chk("load_count_excl", 32'(sif.Load && sif.Count), 32'd0);
            if (sif.Busy) busy_cnt++;
            if (sif.Done) begin
                chk("done_expected", 32'(sif.Done), 32'(sb.size() != 0));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("busy_cycles", 32'(busy_cnt), 32'(e.busy));
                    chk("done_data", 32'(sif.Data_out), 32'(e.data));
                    chk("done_pass", 32'(sif.Pass_idx), 32'(e.pass));
                end
                done_cnt++;
            end
            if (!sif.Busy) busy_cnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.Start  = 1'b0;
        sif.Abort  = 1'b0;
        sif.Hold   = 1'b0;
        sif.Preset = '0;
        sif.Reps   = '0;

        // Reset state
        #2;
        chk("rst_busy", 32'(sif.Busy), 32'd0);
        chk("rst_load", 32'(sif.Load), 32'd0);
        chk("rst_count", 32'(sif.Count), 32'd0);
        chk("rst_done", 32'(sif.Done), 32'd0);
        chk("rst_data", 32'(sif.Data_out), 32'd0);
        chk("rst_pass", 32'(sif.Pass_idx), 32'd0);
        cyc();
        cyc();
        Reset = 1'b0;
        cyc();
        #1;

        // Preset 12, single pass: cycle-accurate walk
        sif.Preset = 4'd12; sif.Reps = 4'd0; sif.Start = 1'b1;
        push(6, 4'd12, 4'd0);
        cyc(); sif.Start = 1'b0; #1;
        chk("s1_c1_load", 32'(sif.Load), 32'd1);
        chk("s1_c1_count", 32'(sif.Count), 32'd0);
        chk("s1_c1_data", 32'(sif.Data_out), 32'd12);
        for (int c = 2; c <= 5; c++) begin
            cyc(); #1;
            chk("s1_run_count", 32'(sif.Count), 32'd1);
            chk("s1_run_cnt", 32'(cnt_q), 32'(12 + c - 2));
            chk("s1_run_cout", 32'(sif.C_out), 32'(c == 5));
        end
        cyc(); #1;
        chk("s1_c6_done", 32'(sif.Done), 32'd1);
        cyc(); #1;
        chk("s1_c7_busy", 32'(sif.Busy), 32'd0);
        chk("s1_c7_done", 32'(sif.Done), 32'd0);
        cyc(); #1;

        // Preset 14, Reps 2: three passes, Pass_idx 0,1,2 at each LOAD
        sif.Preset = 4'd14; sif.Reps = 4'd2; sif.Start = 1'b1;
        push(10, 4'd14, 4'd2);
        for (int c = 1; c <= 9; c++) begin
            cyc(); sif.Start = 1'b0; #1;
            if (c % 3 == 1) begin
                chk("s2_load", 32'(sif.Load), 32'd1);
                chk("s2_pass", 32'(sif.Pass_idx), 32'(c / 3));
            end
        end
        cyc(); #1;
        chk("s2_done_c10", 32'(sif.Done), 32'd1);
        cyc(); cyc(); #1;

        // Hold for 3 cycles with the counter at 13
        sif.Preset = 4'd12; sif.Reps = 4'd0; sif.Start = 1'b1;
        push(9, 4'd12, 4'd0);
        cyc(); sif.Start = 1'b0;
        cyc();
        for (int c = 3; c <= 6; c++) begin
            cyc(); sif.Hold = (c <= 5); #1;
            chk("s3_hold_cnt", 32'(cnt_q), 32'd13);
            chk("s3_hold_count", 32'(sif.Count), 32'(c == 6));
        end
        cyc(); cyc(); cyc(); #1;
        chk("s3_done_c9", 32'(sif.Done), 32'd1);
        cyc(); cyc(); #1;

        // Abort in RUN with counter at 14; no completion queued
        sif.Preset = 4'd12; sif.Reps = 4'd3; sif.Start = 1'b1;
        cyc(); sif.Start = 1'b0;
        cyc(); cyc();
        cyc(); #1;
        chk("s4_cnt14", 32'(cnt_q), 32'd14);
        sif.Abort = 1'b1;
        cyc(); sif.Abort = 1'b0; #1;
        chk("s4_busy", 32'(sif.Busy), 32'd0);
        chk("s4_load", 32'(sif.Load), 32'd0);
        chk("s4_count", 32'(sif.Count), 32'd0);
        chk("s4_done", 32'(sif.Done), 32'd0);
        chk("s4_data", 32'(sif.Data_out), 32'd12);
        repeat (4) cyc();
        #1;

        // Abort beats Start in IDLE
        sif.Preset = 4'd5; sif.Start = 1'b1; sif.Abort = 1'b1;
        cyc(); sif.Start = 1'b0; sif.Abort = 1'b0; #1;
        chk("s4b_busy", 32'(sif.Busy), 32'd0);
        chk("s4b_data", 32'(sif.Data_out), 32'd12);
        cyc(); #1;

        // Start while busy is ignored
        sif.Preset = 4'd12; sif.Reps = 4'd0; sif.Start = 1'b1;
        push(6, 4'd12, 4'd0);
        cyc(); sif.Start = 1'b0;
        cyc(); sif.Start = 1'b1; sif.Preset = 4'd3; sif.Reps = 4'd5;
        cyc(); sif.Start = 1'b0; #1;
        chk("s5_data_kept", 32'(sif.Data_out), 32'd12);
        wait_done(40);
        #1;

        // Reset mid-RUN, then Start right after release
        sif.Preset = 4'd12; sif.Reps = 4'd0; sif.Start = 1'b1;
        cyc(); sif.Start = 1'b0;
        cyc();
        cyc(); Reset = 1'b1; #1;
        chk("s6_busy", 32'(sif.Busy), 32'd0);
        chk("s6_load", 32'(sif.Load), 32'd0);
        chk("s6_count", 32'(sif.Count), 32'd0);
        chk("s6_done", 32'(sif.Done), 32'd0);
        chk("s6_data", 32'(sif.Data_out), 32'd0);
        chk("s6_pass", 32'(sif.Pass_idx), 32'd0);
        cyc(); Reset = 1'b0;
        sif.Preset = 4'd14; sif.Reps = 4'd0; sif.Start = 1'b1;
        push(4, 4'd14, 4'd0);
        cyc(); sif.Start = 1'b0; #1;
        chk("s6_restart_load", 32'(sif.Load), 32'd1);
        chk("s6_restart_data", 32'(sif.Data_out), 32'd14);
        wait_done(40);
        #1;

        // Preset boundaries and maximum repeat count
        sif.Preset = 4'd15; sif.Reps = 4'd1; sif.Start = 1'b1;
        push(5, 4'd15, 4'd1);
        cyc(); sif.Start = 1'b0;
        wait_done(40);
        #1;
        sif.Preset = 4'd0; sif.Reps = 4'd0; sif.Start = 1'b1;
        push(18, 4'd0, 4'd0);
        cyc(); sif.Start = 1'b0;
        wait_done(60);
        #1;
        sif.Preset = 4'd15; sif.Reps = 4'd15; sif.Start = 1'b1;
        push(33, 4'd15, 4'd15);
        cyc(); sif.Start = 1'b0;
        wait_done(80);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
